// File: rtl/logic_unit_sched_pkg.sv
// Shared definitions for the logic-unit scheduler.
// Contents:
//   OP_AND/OP_OR/OP_XOR/OP_NAND : 2-bit gate-bank op select codes.
//   state_t (ST_IDLE, ST_SETTLE) : scheduler FSM states.
package tinycpu_lu_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

endpackage

// File: rtl/logic_unit_sched_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  PW    highest-priority position this round
//   onehot out NREQ  one-hot winner (all zero when no request)
//   idx    out PW    winner index (0 when no request)
//   any    out 1     at least one request is set
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    // Scan from the farthest position back toward ptr so that the last hit
    // written is the first set request at or after ptr.
    always_comb begin
        logic [PW-1:0] pos;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = PW'((int'(ptr) + k) % NREQ);
            if (req[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign onehot[gi] = any && (idx == PW'(gi));
    end

endmodule

// File: rtl/logic_unit_sched.sv
// Round-robin scheduler sharing one bitwise gate bank among NREQ requesters.
// The granted requester's operands are registered onto lu_a/lu_b/lu_sel and
// held for SETTLE cycles, after which lu_y is captured into result and done
// pulses for that requester. Dropping req mid-settle aborts without done.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req[NREQ]             per-requester request
//   op_a/op_b[NREQ*WIDTH] operands, requester i at [i*WIDTH +: WIDTH]
//   op_sel[NREQ*2]        op select, requester i at [2i +: 2]
//   gnt[NREQ]             one-hot grant during settle
//   done[NREQ]            one-cycle completion pulse
//   result[WIDTH]         last captured lu_y
//   busy                  operation in flight
//   lu_a/lu_b/lu_sel      registered drive to gate bank
//   lu_y                  gate bank output
module logic_unit_sched
    import tinycpu_lu_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   op_a,
    input  logic [NREQ*WIDTH-1:0]   op_b,
    input  logic [NREQ*2-1:0]       op_sel,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        result,
    output logic                    busy,
    output logic [WIDTH-1:0]        lu_a,
    output logic [WIDTH-1:0]        lu_b,
    output logic [1:0]              lu_sel,
    input  logic [WIDTH-1:0]        lu_y
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(SETTLE + 1);

    state_t            state_reg, state_next;
    logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]     owner_reg, owner_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic [WIDTH-1:0]  lu_a_reg, lu_a_next;
    logic [WIDTH-1:0]  lu_b_reg, lu_b_next;
    logic [1:0]        lu_sel_reg, lu_sel_next;

    logic [NREQ-1:0]   win_onehot;
    logic [PW-1:0]     win_idx;
    logic              win_any;
    logic [PW-1:0]     owner_succ;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr_reg),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // Pointer always moves one past the owner, whether it finished or aborted.
    assign owner_succ = (owner_reg == PW'(NREQ - 1)) ? '0 : owner_reg + PW'(1);

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        cnt_next    = cnt_reg;
        gnt_next    = gnt_reg;
        done_next   = '0;
        result_next = result_reg;
        lu_a_next   = lu_a_reg;
        lu_b_next   = lu_b_reg;
        lu_sel_next = lu_sel_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_any) begin
                    state_next  = ST_SETTLE;
                    owner_next  = win_idx;
                    gnt_next    = win_onehot;
                    cnt_next    = CW'(SETTLE);
                    lu_a_next   = op_a[win_idx*WIDTH +: WIDTH];
                    lu_b_next   = op_b[win_idx*WIDTH +: WIDTH];
                    lu_sel_next = op_sel[win_idx*2 +: 2];
                end
            end
            ST_SETTLE: begin
                // Abort takes precedence over completion on the final cycle.
                if (!req[owner_reg]) begin
                    state_next  = ST_IDLE;
                    gnt_next    = '0;
                    cnt_next    = '0;
                    rr_ptr_next = owner_succ;
                end else if (cnt_reg == CW'(1)) begin
                    state_next  = ST_IDLE;
                    result_next = lu_y;
                    done_next   = gnt_reg;
                    gnt_next    = '0;
                    cnt_next    = '0;
                    rr_ptr_next = owner_succ;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            cnt_reg    <= '0;
            gnt_reg    <= '0;
            done_reg   <= '0;
            result_reg <= '0;
            lu_a_reg   <= '0;
            lu_b_reg   <= '0;
            lu_sel_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            cnt_reg    <= cnt_next;
            gnt_reg    <= gnt_next;
            done_reg   <= done_next;
            result_reg <= result_next;
            lu_a_reg   <= lu_a_next;
            lu_b_reg   <= lu_b_next;
            lu_sel_reg <= lu_sel_next;
        end
    end

    assign gnt    = gnt_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign busy   = |gnt_reg;
    assign lu_a   = lu_a_reg;
    assign lu_b   = lu_b_reg;
    assign lu_sel = lu_sel_reg;

endmodule

// File: tb/tb_logic_unit_sched.sv
// Self-checking bench for logic_unit_sched: table of op vectors, hand-written
// corner sequences, and a randomized phase, all compared every cycle against
// a transaction-level reference model.
module tb_logic_unit_sched;
    import tinycpu_lu_pkg::*;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 8;
    localparam int SETTLE = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a, op_b;
    logic [NREQ*2-1:0]     op_sel;
    logic [NREQ-1:0]       gnt, done;
    logic [WIDTH-1:0]      result, lu_a, lu_b, lu_y;
    logic                  busy;
    logic [1:0]            lu_sel;

    logic_unit_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .op_sel(op_sel), .gnt(gnt), .done(done), .result(result),
        .busy(busy), .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_y(lu_y)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] s);
        case (s)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    assign lu_y = gate(lu_a, lu_b, lu_sel);

    // Reference model: one transaction at a time, owner = -1 when idle.
    int               m_owner, m_elapsed, m_ptr;
    logic [WIDTH-1:0] m_a, m_b, m_result;
    logic [1:0]       m_sel;
    logic [NREQ-1:0]  m_done;

    int checks = 0;
    int errors = 0;
    int gnt_log[$];
    logic [NREQ-1:0] prev_gnt;

    typedef struct {
        int               who;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       sel;
        logic [WIDTH-1:0] exp;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_owner = -1; m_elapsed = 0; m_ptr = 0;
            m_a = '0; m_b = '0; m_sel = '0; m_result = '0; m_done = '0;
        end else begin
            m_done = '0;
            if (m_owner < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NREQ;
                    if (req[c]) begin
                        m_owner   = c;
                        m_elapsed = 0;
                        m_a   = op_a[c*WIDTH +: WIDTH];
                        m_b   = op_b[c*WIDTH +: WIDTH];
                        m_sel = op_sel[c*2 +: 2];
                        break;
                    end
                end
            end else begin
                m_elapsed++;
                if (!req[m_owner]) begin
                    $display("txn abort requester %0d", m_owner);
                    m_ptr = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end else if (m_elapsed == SETTLE) begin
                    m_result = gate(m_a, m_b, m_sel);
                    m_done[m_owner] = 1'b1;
                    m_ptr = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
        check("gnt", 32'(gnt), 32'(eg));
        check("done", 32'(done), 32'(m_done));
        check("result", 32'(result), 32'(m_result));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("lu_a", 32'(lu_a), 32'(m_a));
        check("lu_b", 32'(lu_b), 32'(m_b));
        check("lu_sel", 32'(lu_sel), 32'(m_sel));
        check("done_vs_gnt", 32'(done & gnt), 32'd0);
        if (done !== '0) $display("txn done=%b result=%h", done, result);
        if (gnt !== '0 && prev_gnt === '0)
            for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
        prev_gnt = gnt;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        step(); step();
        rst = 1'b0;
        gnt_log.delete();
    endtask

    task automatic set_ops(input int who, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [1:0] s);
        op_a[who*WIDTH +: WIDTH] = a;
        op_b[who*WIDTH +: WIDTH] = b;
        op_sel[who*2 +: 2] = s;
    endtask

    task automatic run_op(input vec_t v, input string name);
        int n;
        bit seen;
        set_ops(v.who, v.a, v.b, v.sel);
        req[v.who] = 1'b1;
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (done[v.who]) seen = 1;
        end
        check({name, "_completed"}, 32'(seen), 32'd1);
        check({name, "_latency"}, n, SETTLE + 1);
        check({name, "_result"}, 32'(result), 32'(v.exp));
        req[v.who] = 1'b0;
        step();
    endtask

    initial begin
        logic [WIDTH-1:0] r0;
        int n;
        rst = 1'b1; req = '0; op_a = '0; op_b = '0; op_sel = '0;
        prev_gnt = '0;
        m_owner = -1; m_elapsed = 0; m_ptr = 0;
        m_a = '0; m_b = '0; m_sel = '0; m_result = '0; m_done = '0;

        vecs[0] = '{1, 8'hCC, 8'hAA, OP_AND,  8'h88};
        vecs[1] = '{2, 8'hCC, 8'hAA, OP_OR,   8'hEE};
        vecs[2] = '{3, 8'hCC, 8'hAA, OP_XOR,  8'h66};
        vecs[3] = '{0, 8'hCC, 8'hAA, OP_NAND, 8'h77};

        // Reset state
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_lu_a", 32'(lu_a), 32'd0);

        // Basic AND with exact latency
        set_ops(0, 8'hF0, 8'h3C, OP_AND);
        req = 4'b0001;
        step(); check("t1_gnt_c1", 32'(gnt), 32'h1);
        step(); check("t1_gnt_c2", 32'(gnt), 32'h1);
        step(); check("t1_done", 32'(done), 32'h1);
        check("t1_result", 32'(result), 32'h30);
        req = '0;
        step(); check("t1_done_pulse", 32'(done), 32'h0);
        check("t1_result_hold", 32'(result), 32'h30);

        // Op table
        for (int i = 0; i < 4; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // All requesting, each drops on its done
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, WIDTH'(i * 17), 8'h5A, 2'(i));
        req = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            step();
            req = req & ~done;
        end
        check("rr_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check($sformatf("rr_order%0d", i), gnt_log[i], i);
        req = '0; step();

        // Two held requesters alternate
        do_reset();
        req = 4'b1010;
        for (int c = 0; c < 13; c++) step();
        check("alt_count", 32'(gnt_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check($sformatf("alt%0d", i), gnt_log[i], (i % 2 == 0) ? 1 : 3);
        req = '0; step(); step(); step();

        // Abort in first settle cycle
        do_reset();
        set_ops(3, 8'h0F, 8'hFF, OP_XOR);
        req = 4'b0100;
        step(); check("ab_gnt", 32'(gnt), 32'h4);
        r0 = result;
        req = 4'b1000;
        step(); check("ab_gnt_off", 32'(gnt), 32'h0);
        check("ab_no_done", 32'(done), 32'h0);
        check("ab_result", 32'(result), 32'(r0));
        step(); check("ab_next_gnt", 32'(gnt), 32'h8);
        req = '0; step(); step();

        // Reset mid-settle
        do_reset();
        req = 4'b0010;
        n = 0;
        while (done[1] !== 1'b1 && n < 20) begin step(); n++; end
        check("rs_first_done", 32'(done[1]), 32'd1);
        req = 4'b1000;
        step(); check("rs_gnt3", 32'(gnt), 32'h8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs_gnt", 32'(gnt), 32'h0);
        check("rs_done", 32'(done), 32'h0);
        check("rs_result", 32'(result), 32'h0);
        check("rs_lu", 32'({lu_a, lu_b, lu_sel}), 32'h0);
        check("rs_busy", 32'(busy), 32'h0);
        req = 4'b1111;
        step(); check("rs_gnt0", 32'(gnt), 32'h1);
        req = '0; step(); step();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) req[i] = ($urandom_range(0, 7) != 0);
                else        req[i] = ($urandom_range(0, 3) == 0);
            end
            op_a = {$urandom, $urandom};
            op_b = {$urandom, $urandom};
            op_sel = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
